axi_read_burst_gen: RTL and testbench

//  AXI4 read-address generator and R-channel sequencer that feeds the byte aligner (burst_align).
//  - Accepts a byte address/length, then issues INCR bursts that respect MAX_BURST and 4KB boundaries.
//  - Drives rready and forwards read data, together with offset/start/burst_last/transfer_last, to the aligner.
//  - Supports one outstanding burst at a time.

---
 rtl/axi_read_burst_gen_pkg.sv | 23 ++
 rtl/axi_read_burst_gen_len_calc.sv | 35 +++
 rtl/axi_read_burst_gen.sv | 186 ++++++++++++++++++
 tb/tb_axi_read_burst_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_burst_gen_pkg.sv
// Shared definitions for the AXI read burst generator.
//  - FSM state encoding
//  - AXI burst-type and response encodings
//  - helper deriving the byte-offset width from the data-bus width
package axi_read_burst_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Number of address bits that select a byte within one data beat.
    function automatic int unsigned calc_offset_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_read_burst_gen_len_calc.sv
// Combinational burst-size calculator.
//  beats_o = min(remaining_i, MAX_BURST, beats left before the next 4KB boundary)
// Ports:
//  base_lo_i    low 12 bits of the beat-aligned burst address
//  remaining_i  beats still to be read for the transfer
//  beats_o      beats in the next burst (1..MAX_BURST when remaining_i != 0)
module axi_read_burst_gen_len_calc #(
    parameter int unsigned AXI_LEN_W = 8,
    parameter int unsigned LEN_W     = 20,
    parameter int unsigned MAX_BURST = 256,
    parameter int unsigned OFFSET_W  = 2
) (
    input  logic [11:0]        base_lo_i,
    input  logic [LEN_W:0]     remaining_i,
    output logic [AXI_LEN_W:0] beats_o
);

    logic [31:0] rem_w;
    logic [31:0] room_w;
    logic [31:0] min_w;

    always_comb begin
        rem_w  = 32'(remaining_i);
        room_w = (32'd4096 - 32'(base_lo_i)) >> OFFSET_W;
        min_w  = rem_w;
        if (32'(MAX_BURST) < min_w) begin
            min_w = 32'(MAX_BURST);
        end
        if (room_w < min_w) begin
            min_w = room_w;
        end
        beats_o = (AXI_LEN_W + 1)'(min_w);
    end

endmodule

// File: rtl/axi_read_burst_gen.sv
// AXI4 read-address generator and R-channel sequencer feeding the byte aligner.
// Splits a byte address/length request into INCR bursts bounded by MAX_BURST and 4KB
// pages, one burst outstanding at a time, and forwards R data with alignment framing.
// Ports:
//  clk_i, rst_n_i          clock, synchronous active-low reset
//  run_i/addr_i/length_i   transfer request (sampled in idle only)
//  busy_o/done_o/error_o   transfer status
//  m_ar*                   AXI read-address channel
//  m_r*                    AXI read-data channel
//  offset_o/start_o/burst_last_o/transfer_last_o/data_o/valid_o  aligner interface
module axi_read_burst_gen
    import axi_read_burst_gen_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned LEN_W      = 20,
    parameter int unsigned MAX_BURST  = 256,
    localparam int unsigned OFFSET_W  = calc_offset_w(AXI_DATA_W)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  run_i,
    input  logic [AXI_ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]      length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [AXI_ADDR_W-1:0] m_araddr_o,
    output logic [AXI_LEN_W-1:0]  m_arlen_o,
    output logic [2:0]            m_arsize_o,
    output logic [1:0]            m_arburst_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [AXI_DATA_W-1:0] m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic                  m_rlast_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic [OFFSET_W-1:0]   offset_o,
    output logic                  start_o,
    output logic                  burst_last_o,
    output logic                  transfer_last_o,
    output logic [AXI_DATA_W-1:0] data_o,
    output logic                  valid_o
);

    localparam int unsigned BYTES = AXI_DATA_W / 8;

    state_e                state_q, state_d;
    logic [AXI_ADDR_W-1:0] base_q, base_d;
    logic [LEN_W:0]        rem_q, rem_d;
    logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
    logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic                  start_q, start_d;
    logic                  error_q, error_d;
    logic                  tlast_q, tlast_d;

    logic [AXI_LEN_W:0]    beats;
    logic [AXI_ADDR_W-1:0] burst_bytes;
    logic                  beat;

    // Sized from next-state values so arlen can be registered on the edge entering StAddr.
    axi_read_burst_gen_len_calc #(
        .AXI_LEN_W (AXI_LEN_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .OFFSET_W  (OFFSET_W)
    ) u_len_calc (
        .base_lo_i   (base_d[11:0]),
        .remaining_i (rem_d),
        .beats_o     (beats)
    );

    assign burst_bytes = AXI_ADDR_W'({1'b0, arlen_q} + (AXI_LEN_W + 1)'(1)) << OFFSET_W;
    assign beat        = m_rvalid_i & (state_q == StData);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rem_d      = rem_q;
        beat_cnt_d = beat_cnt_q;
        offset_d   = offset_q;
        start_d    = 1'b0;
        error_d    = error_q;
        unique case (state_q)
            StIdle: begin
                if (run_i) begin
                    base_d   = addr_i & ~AXI_ADDR_W'(BYTES - 1);
                    offset_d = addr_i[OFFSET_W-1:0];
                    rem_d    = ((LEN_W + 1)'(length_i) + (LEN_W + 1)'(addr_i[OFFSET_W-1:0])
                                + (LEN_W + 1)'(BYTES - 1)) >> OFFSET_W;
                    error_d  = 1'b0;
                    if (length_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StAddr;
                        start_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (m_arready_i) begin
                    state_d    = StData;
                    beat_cnt_d = '0;
                end
            end
            StData: begin
                if (beat) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (m_rresp_i != AXI_RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    if (m_rlast_i) begin
                        // Early rlast is flagged but still closes the burst.
                        if (beat_cnt_q != arlen_q) begin
                            error_d = 1'b1;
                        end
                        base_d  = base_q + burst_bytes;
                        state_d = (rem_d == '0) ? StDone : StAddr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        arlen_d = arlen_q;
        tlast_d = tlast_q;
        if ((state_d == StAddr) && (state_q != StAddr)) begin
            arlen_d = AXI_LEN_W'(beats - (AXI_LEN_W + 1)'(1));
            tlast_d = (rem_d == (LEN_W + 1)'(beats));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            base_q     <= '0;
            rem_q      <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            offset_q   <= '0;
            start_q    <= 1'b0;
            error_q    <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            offset_q   <= offset_d;
            start_q    <= start_d;
            error_q    <= error_d;
            tlast_q    <= tlast_d;
        end
    end

    assign busy_o          = (state_q != StIdle);
    assign done_o          = (state_q == StDone);
    assign error_o         = error_q;
    assign m_araddr_o      = base_q;
    assign m_arlen_o       = arlen_q;
    assign m_arsize_o      = 3'(OFFSET_W);
    assign m_arburst_o     = AXI_BURST_INCR;
    assign m_arvalid_o     = (state_q == StAddr);
    assign m_rready_o      = (state_q == StData);
    assign offset_o        = offset_q;
    assign start_o         = start_q;
    assign valid_o         = m_rvalid_i & m_rready_o;
    assign burst_last_o    = valid_o & m_rlast_i;
    assign transfer_last_o = tlast_q & ((state_q == StAddr) | (state_q == StData));
    assign data_o          = m_rdata_i;

endmodule

// File: tb/tb_axi_read_burst_gen.sv
module tb_axi_read_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        run_i;
    logic [31:0] addr_i;
    logic [19:0] length_i;
    logic        busy_o, done_o, error_o;
    logic [31:0] m_araddr_o;
    logic [7:0]  m_arlen_o;
    logic [2:0]  m_arsize_o;
    logic [1:0]  m_arburst_o;
    logic        m_arvalid_o, m_arready_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rlast_i, m_rvalid_i, m_rready_o;
    logic [1:0]  offset_o;
    logic        start_o, burst_last_o, transfer_last_o, valid_o;
    logic [31:0] data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_read_burst_gen dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .run_i           (run_i),
        .addr_i          (addr_i),
        .length_i        (length_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .m_araddr_o      (m_araddr_o),
        .m_arlen_o       (m_arlen_o),
        .m_arsize_o      (m_arsize_o),
        .m_arburst_o     (m_arburst_o),
        .m_arvalid_o     (m_arvalid_o),
        .m_arready_i     (m_arready_i),
        .m_rdata_i       (m_rdata_i),
        .m_rresp_i       (m_rresp_i),
        .m_rlast_i       (m_rlast_i),
        .m_rvalid_i      (m_rvalid_i),
        .m_rready_o      (m_rready_o),
        .offset_o        (offset_o),
        .start_o         (start_o),
        .burst_last_o    (burst_last_o),
        .transfer_last_o (transfer_last_o),
        .data_o          (data_o),
        .valid_o         (valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [19:0] len;
        logic [1:0]  off;
        int          nb;
        logic [31:0] ar0;
        logic [7:0]  len0;
        logic        tl0;
        logic [31:0] ar1;
        logic [7:0]  len1;
        logic        tl1;
        int          ar_delay;
        int          err_beat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v);
        int cyc;
        int nbeats;
        addr_i   = v.addr;
        length_i = v.len;
        run_i    = 1'b1;
        tick();
        run_i = 1'b0;
        chk("start", 32'(start_o), 1);
        chk("offset", 32'(offset_o), 32'(v.off));
        chk("busy_run", 32'(busy_o), 1);
        chk("error_clr", 32'(error_o), 0);
        for (int b = 0; b < v.nb; b++) begin
            cyc = 0;
            while (!m_arvalid_o && cyc < 50) begin
                tick();
                cyc++;
            end
            chk("arvalid_lat", 32'(cyc), 0);
            for (int d = 0; d < v.ar_delay; d++) begin
                tick();
                chk("arvalid_hold", 32'(m_arvalid_o), 1);
                chk("araddr_stable", m_araddr_o, (b == 0) ? v.ar0 : v.ar1);
            end
            chk("araddr", m_araddr_o, (b == 0) ? v.ar0 : v.ar1);
            chk("arlen", 32'(m_arlen_o), 32'((b == 0) ? v.len0 : v.len1));
            chk("arsize", 32'(m_arsize_o), 2);
            chk("arburst", 32'(m_arburst_o), 1);
            chk("tlast_ar", 32'(transfer_last_o), 32'((b == 0) ? v.tl0 : v.tl1));
            m_arready_i = 1'b1;
            tick();
            m_arready_i = 1'b0;
            chk("rready", 32'(m_rready_o), 1);
            chk("arvalid_drop", 32'(m_arvalid_o), 0);
            nbeats = ((b == 0) ? int'(v.len0) : int'(v.len1)) + 1;
            for (int k = 0; k < nbeats; k++) begin
                m_rvalid_i = 1'b1;
                m_rdata_i  = {8'(b), 8'(k), 16'hA5C3};
                m_rlast_i  = (k == nbeats - 1);
                m_rresp_i  = (b == 0 && k == v.err_beat) ? 2'b10 : 2'b00;
                #1;
                chk("valid", 32'(valid_o), 1);
                chk("data", data_o, {8'(b), 8'(k), 16'hA5C3});
                chk("burst_last", 32'(burst_last_o), 32'(k == nbeats - 1));
                if (k == nbeats - 1) begin
                    chk("tlast_beat", 32'(transfer_last_o), 32'((b == 0) ? v.tl0 : v.tl1));
                end
                tick();
            end
            m_rvalid_i = 1'b0;
            m_rlast_i  = 1'b0;
            m_rresp_i  = 2'b00;
        end
        chk("done", 32'(done_o), 1);
        chk("busy_done", 32'(busy_o), 1);
        tick();
        chk("done_pulse", 32'(done_o), 0);
        chk("busy_idle", 32'(busy_o), 0);
        chk("error_end", 32'(error_o), 32'(v.exp_err));
    endtask

    initial begin
        //        addr          len     off nb  ar0           l0   t0  ar1           l1   t1  dly eb  err
        vecs[0] = '{32'h0000_1000, 20'd16, 2'd0, 1, 32'h0000_1000, 8'd3, 1'b1, 32'h0, 8'd0, 1'b0, 0, -1, 1'b0};
        vecs[1] = '{32'h0000_1002, 20'd8, 2'd2, 1, 32'h0000_1000, 8'd2, 1'b1, 32'h0, 8'd0, 1'b0, 1, -1, 1'b0};
        vecs[2] = '{32'h0000_0FF8, 20'd32, 2'd0, 2, 32'h0000_0FF8, 8'd1, 1'b0,
                    32'h0000_1000, 8'd5, 1'b1, 0, -1, 1'b0};
        vecs[3] = '{32'h0000_0000, 20'd2048, 2'd0, 2, 32'h0000_0000, 8'd255, 1'b0,
                    32'h0000_0400, 8'd255, 1'b1, 5, -1, 1'b0};
        vecs[4] = '{32'h0000_1000, 20'd16, 2'd0, 1, 32'h0000_1000, 8'd3, 1'b1, 32'h0, 8'd0, 1'b0, 0, 1, 1'b1};
        vecs[5] = '{32'h0000_1FFE, 20'd4, 2'd2, 2, 32'h0000_1FFC, 8'd0, 1'b0,
                    32'h0000_2000, 8'd0, 1'b1, 0, -1, 1'b0};

        rst_n_i     = 1'b0;
        run_i       = 1'b0;
        addr_i      = '0;
        length_i    = '0;
        m_arready_i = 1'b0;
        m_rdata_i   = '0;
        m_rresp_i   = 2'b00;
        m_rlast_i   = 1'b0;
        m_rvalid_i  = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_arvalid", 32'(m_arvalid_o), 0);
        chk("rst_rready", 32'(m_rready_o), 0);
        chk("rst_start", 32'(start_o), 0);
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i]);
            tick();
        end

        // Zero-length transfer: no AR, no start pulse, done right after acceptance.
        addr_i   = 32'h0000_2000;
        length_i = '0;
        run_i    = 1'b1;
        tick();
        run_i = 1'b0;
        chk("z_start", 32'(start_o), 0);
        chk("z_arvalid", 32'(m_arvalid_o), 0);
        chk("z_done", 32'(done_o), 1);
        chk("z_busy", 32'(busy_o), 1);
        tick();
        chk("z_done_pulse", 32'(done_o), 0);
        chk("z_arvalid2", 32'(m_arvalid_o), 0);
        chk("z_busy_idle", 32'(busy_o), 0);

        // run_i while busy is ignored; reset mid-DATA aborts without done.
        addr_i   = 32'h0000_1002;
        length_i = 20'd64;
        run_i    = 1'b1;
        tick();
        addr_i   = 32'h0000_3003;
        length_i = 20'd4;
        tick();
        run_i = 1'b0;
        chk("ign_arvalid", 32'(m_arvalid_o), 1);
        chk("ign_araddr", m_araddr_o, 32'h0000_1000);
        chk("ign_offset", 32'(offset_o), 2);
        chk("ign_start", 32'(start_o), 0);
        chk("ign_arlen", 32'(m_arlen_o), 16);
        m_arready_i = 1'b1;
        tick();
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b1;
        m_rdata_i   = 32'h1234_5678;
        repeat (2) tick();
        m_rvalid_i = 1'b0;
        chk("mid_rready", 32'(m_rready_o), 1);
        rst_n_i = 1'b0;
        tick();
        chk("abort_rready", 32'(m_rready_o), 0);
        chk("abort_arvalid", 32'(m_arvalid_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_offset", 32'(offset_o), 0);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(done_o), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
